// File: rtl/vfm_trace_pkg.sv
// ---------------------------------------------------------------------------
// vfm_trace_pkg
// Shared definitions for the instruction-trace streamer:
//   - opcode encodings (6-bit field at the top of the IR)
//   - mnemonic(): 64-entry opcode -> 5-char space-padded ASCII lookup
//   - hex_char(): nibble -> ASCII hex digit
//   - ASCII constants, record length constants, FSM state enum
// Optional macro VFM_TRACE_SEQ_EN lengthens every record by a
// 3-char "HH " sequence-number prefix.
// ---------------------------------------------------------------------------
package vfm_trace_pkg;

    // Opcode encodings; every code not listed decodes as "NDEF "
    localparam logic [5:0] OP_HALT = 6'd0;
    localparam logic [5:0] OP_LD   = 6'd1;
    localparam logic [5:0] OP_ST   = 6'd2;
    localparam logic [5:0] OP_MOV  = 6'd3;
    localparam logic [5:0] OP_CMP  = 6'd4;
    localparam logic [5:0] OP_ADD  = 6'd5;
    localparam logic [5:0] OP_SUB  = 6'd6;
    localparam logic [5:0] OP_AND  = 6'd7;
    localparam logic [5:0] OP_OR   = 6'd8;
    localparam logic [5:0] OP_XOR  = 6'd9;
    localparam logic [5:0] OP_SHL  = 6'd10;
    localparam logic [5:0] OP_SHR  = 6'd11;
    localparam logic [5:0] OP_JMP  = 6'd16;
    localparam logic [5:0] OP_JZ   = 6'd17;
    localparam logic [5:0] OP_NOP  = 6'd56;

    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    // Decoded body is always 12 characters (96 bits)
    localparam int BODY_CHARS = 12;
`ifdef VFM_TRACE_SEQ_EN
    localparam int SEQ_CHARS = 3;
`else
    localparam int SEQ_CHARS = 0;
`endif
    // Characters shifted out before the LF, and full record length
    localparam int REC_CHARS = SEQ_CHARS + BODY_CHARS;
    localparam int REC_LEN   = REC_CHARS + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_EOL
    } state_t;

    function automatic logic [39:0] mnemonic(input logic [5:0] op);
        case (op)
            OP_HALT: return "HALT ";
            OP_LD:   return "LD   ";
            OP_ST:   return "ST   ";
            OP_MOV:  return "MOV  ";
            OP_CMP:  return "CMP  ";
            OP_ADD:  return "ADD  ";
            OP_SUB:  return "SUB  ";
            OP_AND:  return "AND  ";
            OP_OR:   return "OR   ";
            OP_XOR:  return "XOR  ";
            OP_SHL:  return "SHL  ";
            OP_SHR:  return "SHR  ";
            OP_JMP:  return "JMP  ";
            OP_JZ:   return "JZ   ";
            OP_NOP:  return "NOP  ";
            default: return "NDEF ";
        endcase
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/vfm_ir_ascii_fmt.sv
// ---------------------------------------------------------------------------
// vfm_ir_ascii_fmt
// Purely combinational: instruction word -> 12-char ASCII record,
// character 0 in the most significant byte.
//   "MMMMMRdd,Rss"  mnemonic, dst and src as two decimal digits
//   all-ones IR  -> "STALL       "
// Ports:
//   i_ir   [IR_W-1:0]  instruction word (opcode in top 6 bits,
//                      dst in [9:5], src in [4:0])
//   o_rec  [95:0]      formatted record
// ---------------------------------------------------------------------------
module vfm_ir_ascii_fmt
    import vfm_trace_pkg::*;
#(
    parameter int IR_W = 16
) (
    input  logic [IR_W-1:0] i_ir,
    output logic [95:0]     o_rec
);

    // 0..31 -> two ASCII decimal digits
    function automatic logic [15:0] dec2(input logic [4:0] v);
        logic [1:0] tens;
        logic [4:0] ones;
        if (v >= 5'd30) begin
            tens = 2'd3; ones = v - 5'd30;
        end else if (v >= 5'd20) begin
            tens = 2'd2; ones = v - 5'd20;
        end else if (v >= 5'd10) begin
            tens = 2'd1; ones = v - 5'd10;
        end else begin
            tens = 2'd0; ones = v;
        end
        return {8'h30 + {6'h0, tens}, 8'h30 + {3'h0, ones}};
    endfunction

    logic [5:0] w_op;
    logic [4:0] w_dst;
    logic [4:0] w_src;

    assign w_op  = i_ir[IR_W-1 -: 6];
    assign w_dst = i_ir[9:5];
    assign w_src = i_ir[4:0];

    always_comb begin
        // NOTE: o_rec gets a full default before any condition so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        o_rec = {mnemonic(w_op), ASCII_R, dec2(w_dst), ASCII_COMMA,
                 ASCII_R, dec2(w_src)};
        if (&i_ir)
            o_rec = "STALL       ";
    end

endmodule

// File: rtl/vfm_trace_streamer.sv
// ---------------------------------------------------------------------------
// vfm_trace_streamer
// Debug trace tap: captures committed IR words into a FIFO, decodes each
// one into an ASCII record and streams it one byte per valid/ready
// handshake, terminated by LF. Simulation / FPGA debug only.
// Optional macro VFM_TRACE_SEQ_EN: prefix each record with a 2-hex-digit
// sequence number and a space; the number advances on every ir_valid,
// including dropped words, so gaps expose drops.
// Ports:
//   Clk_pin, Resetn_pin   clock, asynchronous active-low reset
//   ir_valid, ir          IR commit strobe and instruction word
//   clear                 synchronous clear of overflow / drop_cnt
//   ch_data, ch_valid     output byte stream
//   ch_ready              consumer accepts byte
//   overflow, drop_cnt    sticky drop flag, saturating drop count
//   busy                  FIFO non-empty or record in flight
// ---------------------------------------------------------------------------
module vfm_trace_streamer
    import vfm_trace_pkg::*;
#(
    parameter int IR_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clk_pin,
    input  logic             Resetn_pin,
    input  logic             ir_valid,
    input  logic [IR_W-1:0]  ir,
    input  logic             clear,
    output logic [7:0]       ch_data,
    output logic             ch_valid,
    input  logic             ch_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam int         REC_W    = REC_CHARS * 8;
    localparam logic [3:0] LAST_IDX = 4'(REC_LEN - 2);
`ifdef VFM_TRACE_SEQ_EN
    localparam int ENT_W = IR_W + 8;
`else
    localparam int ENT_W = IR_W;
`endif

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    state_t           r_state;
    logic [REC_W-1:0] r_buf;
    logic [3:0]       r_idx;
    logic [7:0]       r_ch_data;
    logic             r_ch_valid;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_hs;
    logic [ENT_W-1:0] w_wr_entry;
    logic [ENT_W-1:0] w_rd_entry;
    logic [95:0]      w_body;
    logic [REC_W-1:0] w_rec;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = (r_state == ST_LOAD) && !w_empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts
    assign w_push  = ir_valid && (!w_full || w_pop);
    assign w_drop  = ir_valid && !w_push;
    assign w_hs    = r_ch_valid && ch_ready;

    assign w_rd_entry = r_mem[r_rd_ptr];

    vfm_ir_ascii_fmt #(.IR_W(IR_W)) u_fmt (
        .i_ir  (w_rd_entry[IR_W-1:0]),
        .o_rec (w_body)
    );

`ifdef VFM_TRACE_SEQ_EN
    logic [7:0] r_seq;

    always_ff @(posedge Clk_pin or negedge Resetn_pin) begin
        if (!Resetn_pin)
            r_seq <= 8'd0;
        else if (ir_valid)
            r_seq <= r_seq + 8'd1;
    end

    assign w_wr_entry = {r_seq, ir};
    assign w_rec      = {hex_char(w_rd_entry[ENT_W-1 -: 4]),
                         hex_char(w_rd_entry[ENT_W-5 -: 4]),
                         ASCII_SP, w_body};
`else
    assign w_wr_entry = ir;
    assign w_rec      = w_body;
`endif

    // NOTE: storage array has no reset; emptiness is tracked by r_count,
    // so stale contents are never read and the array maps to plain RAM.
    always_ff @(posedge Clk_pin) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_wr_entry;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drop accounting; clear wins over a same-cycle drop
    always_ff @(posedge Clk_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    // Record FSM: the first character goes straight to r_ch_data on LOAD,
    // the remainder waits in r_buf and is shifted up one byte per handshake.
    always_ff @(posedge Clk_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_idx      <= '0;
            r_ch_data  <= 8'h00;
            r_ch_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty)
                        r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_ch_data  <= w_rec[REC_W-1 -: 8];
                    r_buf      <= w_rec << 8;
                    r_idx      <= '0;
                    r_ch_valid <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        if (r_idx == LAST_IDX) begin
                            r_ch_data <= ASCII_LF;
                            r_state   <= ST_EOL;
                        end else begin
                            r_ch_data <= r_buf[REC_W-1 -: 8];
                            r_buf     <= r_buf << 8;
                        end
                        r_idx <= r_idx + 4'd1;
                    end
                end
                ST_EOL: begin
                    if (w_hs) begin
                        r_ch_valid <= 1'b0;
                        r_ch_data  <= 8'h00;
                        r_state    <= w_empty ? ST_IDLE : ST_LOAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ch_data  = r_ch_data;
    assign ch_valid = r_ch_valid;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
    assign busy     = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_vfm_trace_streamer.sv
// ---------------------------------------------------------------------------
// tb_vfm_trace_streamer
// Directed stimulus with hand-decoded record text. Each accepted push
// queues its expected bytes; an independent monitor pops and compares on
// every ch_valid & ch_ready and checks data/valid stability under stall.
// ---------------------------------------------------------------------------
module tb_vfm_trace_streamer;

    localparam int IR_W  = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic             Clk_pin    = 1'b0;
    logic             Resetn_pin = 1'b0;
    logic             ir_valid   = 1'b0;
    logic [IR_W-1:0]  ir         = '0;
    logic             clear      = 1'b0;
    logic             ch_ready   = 1'b0;
    logic [7:0]       ch_data;
    logic             ch_valid;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    logic             busy;

    vfm_trace_streamer #(.IR_W(IR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk_pin    (Clk_pin),
        .Resetn_pin (Resetn_pin),
        .ir_valid   (ir_valid),
        .ir         (ir),
        .clear      (clear),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 Clk_pin = ~Clk_pin;

    int         n_checks   = 0;
    int         n_errors   = 0;
    logic [7:0] exp_q[$];
    int         hs_count   = 0;
    int         rec_count  = 0;
    int         ready_mode = 0;   // 0 low, 1 high, 2 toggle
    logic [7:0] tb_seq     = 8'd0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    // Overflow burst: first 9 are accepted (1 into the shift buffer,
    // 8 into the FIFO), the last 3 are dropped.
    logic [15:0] ovf_ir [12] = '{16'h1471, 16'h1945, 16'h07E0, 16'h0822,
                                 16'h1D9D, 16'h2289, 16'h24FE, 16'h0E6B,
                                 16'hE000, 16'h1471, 16'h1471, 16'h1471};
    string       ovf_txt [12] = '{"ADD  R03,R17", "SUB  R10,R05",
                                  "LD   R31,R00", "ST   R01,R02",
                                  "AND  R12,R29", "OR   R20,R09",
                                  "XOR  R07,R30", "MOV  R19,R11",
                                  "NOP  R00,R00", "", "", ""};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic push(input logic [IR_W-1:0] v, input string txt,
                        input bit accept);
        ir       = v;
        ir_valid = 1'b1;
        if (accept) begin
`ifdef VFM_TRACE_SEQ_EN
            exp_q.push_back(hexc(tb_seq[7:4]));
            exp_q.push_back(hexc(tb_seq[3:0]));
            exp_q.push_back(8'h20);
`endif
            for (int i = 0; i < 12; i++)
                exp_q.push_back(txt[i]);
            exp_q.push_back(8'h0A);
        end
        tb_seq = tb_seq + 8'd1;
        @(posedge Clk_pin); #1;
        ir_valid = 1'b0;
    endtask

    task automatic set_ready(input int m);
        ready_mode = m;
        repeat (2) @(posedge Clk_pin);
        #1;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
            @(posedge Clk_pin);
            n++;
        end
        check("drain_in_time", 32'(n < max_cycles), 1);
        @(negedge Clk_pin);
        check("idle_busy", busy, 0);
        check("idle_valid", ch_valid, 0);
    endtask

    // ch_ready driver, updated just after each active edge
    initial forever begin
        @(posedge Clk_pin); #1;
        case (ready_mode)
            0:       ch_ready = 1'b0;
            1:       ch_ready = 1'b1;
            default: ch_ready = !ch_ready;
        endcase
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge Clk_pin);
        if (!Resetn_pin) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", ch_valid, 1);
                check("stall_hold_data", ch_data, prev_data);
            end
            if (ch_valid && ch_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", hs_count), ch_data, e);
                    if (e == 8'h0A)
                        rec_count++;
                end
                hs_count++;
            end
            prev_stall = ch_valid && !ch_ready;
            prev_data  = ch_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset state
        #12;
        check("rst_ch_valid", ch_valid, 0);
        check("rst_ch_data", ch_data, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_busy", busy, 0);
        @(negedge Clk_pin);
        Resetn_pin = 1'b1;
        @(posedge Clk_pin); #1;

        // Single ADD with latency: push at edge N, first byte after N+2
        set_ready(1);
        push(16'h1471, "ADD  R03,R17", 1'b1);
        @(negedge Clk_pin);
        check("lat_after_n", ch_valid, 0);
        @(negedge Clk_pin);
        check("lat_after_n1", ch_valid, 0);
        @(negedge Clk_pin);
        check("lat_after_n2", ch_valid, 1);
        check("busy_in_record", busy, 1);
        wait_drain(100);

        // Backpressure: ready toggles each cycle
        ready_mode = 2;
        @(posedge Clk_pin); #1;
        push(16'h1471, "ADD  R03,R17", 1'b1);
        wait_drain(200);

        // STALL, NOP, undefined opcodes (011111 and 111111 not all-ones)
        set_ready(1);
        push(16'hFFFF, "STALL       ", 1'b1);
        push(16'hE000, "NOP  R00,R00", 1'b1);
        push(16'h7C00, "NDEF R00,R00", 1'b1);
        push(16'hFC21, "NDEF R01,R01", 1'b1);
        wait_drain(200);

        // Overflow with consumer stalled
        set_ready(0);
        for (int i = 0; i < 12; i++)
            push(ovf_ir[i], ovf_txt[i], i < 9);
        @(negedge Clk_pin);
        check("ovf_flag", overflow, 1);
        check("ovf_drop_cnt", drop_cnt, 3);
        check("ovf_busy", busy, 1);
        check("ovf_valid_held", ch_valid, 1);

        // clear together with another drop: clear wins
        @(posedge Clk_pin); #1;
        ir       = 16'h1471;
        ir_valid = 1'b1;
        clear    = 1'b1;
        tb_seq   = tb_seq + 8'd1;
        @(posedge Clk_pin); #1;
        ir_valid = 1'b0;
        clear    = 1'b0;
        @(negedge Clk_pin);
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt", drop_cnt, 0);

        base = rec_count;
        set_ready(1);
        wait_drain(400);
        check("ovf_record_count", rec_count - base, 9);

        // One more record after the drops (sequence gap when enabled)
        push(16'h1471, "ADD  R03,R17", 1'b1);
        wait_drain(100);

        // Reset in the middle of a record with a second one queued
        push(16'h1945, "SUB  R10,R05", 1'b1);
        push(16'h0822, "ST   R01,R02", 1'b1);
        base = hs_count;
        n    = 0;
        while (hs_count < base + 5 && n < 100) begin
            @(posedge Clk_pin);
            n++;
        end
        check("reached_byte5", 32'(n < 100), 1);
        #1;
        check("mid_record_valid", ch_valid, 1);
        #1;
        Resetn_pin = 1'b0;
        exp_q.delete();
        tb_seq = 8'd0;
        #1;
        check("async_rst_valid", ch_valid, 0);
        check("async_rst_data", ch_data, 8'h00);
        check("async_rst_busy", busy, 0);
        repeat (2) @(negedge Clk_pin);
        Resetn_pin = 1'b1;
        repeat (20) @(negedge Clk_pin);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", ch_valid, 0);

        // Recovery after reset
        push(16'h1471, "ADD  R03,R17", 1'b1);
        wait_drain(100);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
